sd_sector_stream_writer: RTL and testbench

Buffers a UART byte stream into whole 512-byte SD sectors and drives the SD controller's sector-write handshake. It sits between the UART receiver (`rx_data`/`rx_flag`) and the SD write controller (`wr_req`/`wr_en`/`wr_busy`). It replaces the edge-clocked write-address counter with a fully synchronous sector address generator, adding configurable wrap and idle-timeout flush with padding. It also provides multi-sector buffering and overflow reporting.

---
 rtl/sd_stream_pkg.sv | 26 ++
 rtl/sd_word_fifo.sv | 58 +++++
 rtl/sd_sector_stream_writer.sv | 161 ++++++++++++++++
 tb/tb_sd_sector_stream_writer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sd_stream_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// sd_stream_pkg : shared sector constants, write-FSM states, byte packing
// Revision      : 1.0
// ----------------------------------------------------------------------
package sd_stream_pkg;

  localparam int SECTOR_WORDS = 256;
  localparam int SECTOR_BYTES = 512;
  localparam int WORD_W       = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    XFER      = 2'd2,
    DONE_WAIT = 2'd3
  } wr_state_t;

  function automatic logic [WORD_W-1:0] pack_word(input logic [7:0] first,
                                                  input logic [7:0] second,
                                                  input logic       msb_first);
    return msb_first ? {first, second} : {second, first};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_word_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------
// sd_word_fifo : synchronous first-word-fall-through word FIFO
// Revision     : 1.0
// ----------------------------------------------------------------------
module sd_word_fifo
  import sd_stream_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WORD_W-1:0]      i_data,
  input  logic                   i_pop,
  output logic [WORD_W-1:0]      o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              w_push;
  logic              w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  // An empty FIFO presents zero rather than stale storage
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sd_sector_stream_writer.sv
`default_nettype none
// ----------------------------------------------------------------------
// sd_sector_stream_writer : UART bytes -> padded 512-byte SD sector writes
// Revision                : 1.0
// ----------------------------------------------------------------------
module sd_sector_stream_writer
  import sd_stream_pkg::*;
#(
  parameter logic [31:0] START_ADDR   = 32'h100,
  parameter logic [31:0] END_ADDR     = 32'hFFFF_FFFF,
  parameter int          FIFO_SECTORS = 2,
  parameter int unsigned FLUSH_CYCLES = 5_000_000,
  parameter logic [7:0]  PAD_BYTE     = 8'h00,
  parameter bit          MSB_FIRST    = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_flag,
  input  logic        init_end,
  input  logic        wr_busy,
  input  logic        wr_en,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        overflow,
  output logic [31:0] sectors_written
);

  localparam int                c_depth      = FIFO_SECTORS * SECTOR_WORDS;
  localparam int                c_lw         = $clog2(c_depth) + 1;
  localparam logic [c_lw-1:0]   c_sector_lvl = c_lw'(SECTOR_WORDS);
  localparam logic [31:0]       c_flush_last = 32'(FLUSH_CYCLES - 1);
  localparam logic [WORD_W-1:0] c_pad_word   = {PAD_BYTE, PAD_BYTE};

  logic              r_pend_valid, r_rdy_valid, r_padding, r_overflow;
  logic [7:0]        r_pend_byte, r_word_cnt, r_pop_cnt;
  logic [WORD_W-1:0] r_rdy_word, r_pad_word, w_push_data;
  logic [31:0]       r_idle_cnt, r_addr, r_sectors;
  logic              w_push, w_pop, w_full, w_empty;
  logic [c_lw-1:0]   w_level;
  logic              w_pad_push, w_rdy_take, w_idle_active, w_flush_hit;
  logic              r_busy_d, r_req_ok, w_busy_fall, w_done;
  wr_state_t         r_state, w_state_nxt;

  sd_word_fifo #(.DEPTH(c_depth)) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (wr_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Padding owns the FIFO write port; a ready word waits until it ends
  assign w_pad_push    = r_padding && !w_full;
  assign w_rdy_take    = r_rdy_valid && !r_padding;
  assign w_push        = w_pad_push || (w_rdy_take && !w_full);
  assign w_push_data   = r_padding ? r_pad_word : r_rdy_word;
  assign w_idle_active = (r_word_cnt != 8'd0) || r_pend_valid;
  assign w_flush_hit   = (FLUSH_CYCLES != 0) && !r_padding && !rx_flag && !r_rdy_valid
                         && w_idle_active && (r_idle_cnt == c_flush_last);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pend_valid <= 1'b0;
      r_pend_byte  <= 8'd0;
      r_rdy_valid  <= 1'b0;
      r_rdy_word   <= '0;
      r_padding    <= 1'b0;
      r_pad_word   <= '0;
      r_word_cnt   <= 8'd0;
      r_idle_cnt   <= 32'd0;
      r_overflow   <= 1'b0;
    end else begin
      if (rx_flag) begin
        if (r_pend_valid) begin
          r_rdy_word   <= pack_word(r_pend_byte, rx_data, MSB_FIRST);
          r_pend_valid <= 1'b0;
        end else begin
          r_pend_byte  <= rx_data;
          r_pend_valid <= 1'b1;
        end
      end else if (w_flush_hit) begin
        r_pend_valid <= 1'b0;
      end

      if (rx_flag && r_pend_valid) r_rdy_valid <= 1'b1;
      else if (w_rdy_take)         r_rdy_valid <= 1'b0;

      if (w_rdy_take && w_full) r_overflow <= 1'b1;

      // The first pad word absorbs a lone pending byte
      if (w_flush_hit) begin
        r_padding  <= 1'b1;
        r_pad_word <= r_pend_valid ? pack_word(r_pend_byte, PAD_BYTE, MSB_FIRST) : c_pad_word;
      end else if (w_pad_push) begin
        r_pad_word <= c_pad_word;
        if (r_word_cnt == 8'hFF) r_padding <= 1'b0;
      end

      if (w_push) r_word_cnt <= r_word_cnt + 8'd1;

      if (rx_flag || r_padding || !w_idle_active || w_flush_hit) r_idle_cnt <= 32'd0;
      else if (r_idle_cnt != c_flush_last)                       r_idle_cnt <= r_idle_cnt + 32'd1;
    end
  end

  assign w_busy_fall = r_busy_d && !wr_busy;
  assign w_done      = (r_state == DONE_WAIT) && w_busy_fall;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= IDLE;
      r_busy_d  <= 1'b0;
      r_req_ok  <= 1'b0;
      r_pop_cnt <= 8'd0;
      r_addr    <= START_ADDR;
      r_sectors <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_busy_d <= wr_busy;
      // Registered qualifier keeps two cycles between IDLE entry and wr_req
      r_req_ok <= (r_state == IDLE) && (w_level >= c_sector_lvl) && init_end && !wr_busy;
      if (r_state == REQ) r_pop_cnt <= 8'd0;
      else if (w_pop)     r_pop_cnt <= r_pop_cnt + 8'd1;
      if (w_done) begin
        r_sectors <= r_sectors + 32'd1;
        r_addr    <= (r_addr == END_ADDR) ? START_ADDR : r_addr + 32'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    wr_req      = 1'b0;
    case (r_state)
      IDLE:      if (r_req_ok && init_end && !wr_busy) w_state_nxt = REQ;
      REQ: begin
        wr_req      = 1'b1;
        w_state_nxt = XFER;
      end
      XFER: begin
        w_pop = wr_en && !w_empty;
        if (w_pop && (r_pop_cnt == 8'hFF)) w_state_nxt = DONE_WAIT;
      end
      DONE_WAIT: if (w_busy_fall) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  assign wr_addr         = r_addr;
  assign overflow        = r_overflow;
  assign sectors_written = r_sectors;

endmodule
`default_nettype wire

// File: tb/tb_sd_sector_stream_writer.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_sd_sector_stream_writer : directed self-checking bench
// Revision                   : 1.0
// ----------------------------------------------------------------------
module tb_sd_sector_stream_writer;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_flag = 1'b0;
  logic        init_end = 1'b0;
  logic        wr_busy = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_req, overflow;
  logic [31:0] wr_addr, sectors_written;
  logic [15:0] wr_data;
  logic        u1_wr_req, u1_overflow;
  logic [31:0] u1_wr_addr, u1_sectors_written;
  logic [15:0] u1_wr_data;

  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  logic [15:0] exp_w [256];

  always #10 sys_clk = ~sys_clk;

  sd_sector_stream_writer #(
    .START_ADDR(32'h100), .END_ADDR(32'h101), .FIFO_SECTORS(1),
    .FLUSH_CYCLES(100), .PAD_BYTE(8'h00), .MSB_FIRST(1'b1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_data), .rx_flag(rx_flag),
    .init_end(init_end), .wr_busy(wr_busy), .wr_en(wr_en), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .overflow(overflow),
    .sectors_written(sectors_written)
  );

  sd_sector_stream_writer #(
    .START_ADDR(32'h100), .END_ADDR(32'h101), .FIFO_SECTORS(1),
    .FLUSH_CYCLES(100), .PAD_BYTE(8'h00), .MSB_FIRST(1'b0)
  ) dut_lsb (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_data), .rx_flag(rx_flag),
    .init_end(init_end), .wr_busy(wr_busy), .wr_en(wr_en), .wr_req(u1_wr_req),
    .wr_addr(u1_wr_addr), .wr_data(u1_wr_data), .overflow(u1_overflow),
    .sectors_written(u1_sectors_written)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_flag = 1'b1;
    tick();
    rx_flag = 1'b0;
  endtask

  task automatic send_bytes(input int n, input int off);
    for (int i = 0; i < n; i++) send_byte(8'(i + off));
  endtask

  task automatic fill_exp(input int off);
    for (int k = 0; k < 256; k++) exp_w[k] = {8'(2 * k + off), 8'(2 * k + 1 + off)};
  endtask

  // Plays the SD controller: waits for wr_req, then pops npop words
  task automatic xfer(input logic [31:0] addr, input int npop, input int budget);
    int          waited = 0;
    int          nbad = 0;
    logic [15:0] first_obs = 16'hxxxx;
    while (!wr_req && waited < budget) begin
      tick();
      waited++;
    end
    check("wr_req_seen", {31'd0, wr_req}, 32'd1);
    check("wr_addr_at_req", wr_addr, addr);
    wr_busy = 1'b1;
    tick();
    check("wr_req_one_cycle", {31'd0, wr_req}, 32'd0);
    wr_en = 1'b1;
    for (int i = 0; i < npop; i++) begin
      if (i == 0) first_obs = wr_data;
      if (wr_data !== exp_w[i]) nbad++;
      tick();
    end
    wr_en = 1'b0;
    check("first_word", {16'd0, first_obs}, {16'd0, exp_w[0]});
    check("word_mismatches", 32'(nbad), 32'd0);
  endtask

  task automatic finish_sector(input logic [31:0] addr, input logic [31:0] nxt, input int nsec);
    tick();
    tick();
    check("wr_addr_stable", wr_addr, addr);
    wr_busy = 1'b0;
    tick();
    tick();
    check("wr_addr_next", wr_addr, nxt);
    check("sectors_written", sectors_written, 32'(nsec));
  endtask

  initial begin
    int nreq;
    tick();
    tick();
    check("rst_wr_req", {31'd0, wr_req}, 32'd0);
    check("rst_wr_addr", wr_addr, 32'h100);
    check("rst_wr_data", {16'd0, wr_data}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_sectors", sectors_written, 32'd0);
    sys_rst_n = 1'b1;
    tick();

    // Byte order: first byte high (MSB_FIRST=1) or low (MSB_FIRST=0)
    send_byte(8'h12);
    send_byte(8'h34);
    tick();
    tick();
    check("msb_first_word", {16'd0, wr_data}, 32'h1234);
    check("lsb_first_word", {16'd0, u1_wr_data}, 32'h3412);
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    tick();
    check("fifo_empty_after_rst", {16'd0, wr_data}, 32'd0);

    // Full sector of 0x00..0xFF repeating
    init_end = 1'b1;
    send_bytes(512, 0);
    fill_exp(0);
    xfer(32'h100, 256, 20);
    finish_sector(32'h100, 32'h101, 1);

    // Partial sector padded out by the idle flush
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    tick();
    tick();
    check("partial_head", {16'd0, wr_data}, 32'hA1B2);
    for (int k = 0; k < 256; k++) exp_w[k] = 16'h0000;
    exp_w[0] = 16'hA1B2;
    exp_w[1] = 16'hC300;
    xfer(32'h101, 256, 500);
    finish_sector(32'h101, 32'h100, 2);

    // Third sector lands on the wrapped address
    send_bytes(512, 7);
    fill_exp(7);
    xfer(32'h100, 256, 20);
    finish_sector(32'h100, 32'h101, 3);

    // Overflow: one-sector FIFO, 514 bytes while SD not ready
    init_end = 1'b0;
    send_bytes(514, 8'h40);
    tick();
    tick();
    check("overflow_set", {31'd0, overflow}, 32'd1);
    check("overflow_head", {16'd0, wr_data}, 32'h4041);
    init_end = 1'b1;
    fill_exp(8'h40);
    xfer(32'h101, 256, 20);
    finish_sector(32'h101, 32'h100, 4);
    nreq = 0;
    for (int i = 0; i < 300; i++) begin
      if (wr_req) nreq++;
      tick();
    end
    check("no_extra_sector", 32'(nreq), 32'd0);
    check("overflow_sticky", {31'd0, overflow}, 32'd1);

    // Reset in the middle of a transfer
    send_bytes(512, 8'h80);
    fill_exp(8'h80);
    xfer(32'h100, 100, 20);
    sys_rst_n = 1'b0;
    wr_busy = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    check("midrst_wr_req", {31'd0, wr_req}, 32'd0);
    check("midrst_wr_addr", wr_addr, 32'h100);
    check("midrst_fifo_empty", {16'd0, wr_data}, 32'd0);
    check("midrst_sectors", sectors_written, 32'd0);
    check("midrst_overflow", {31'd0, overflow}, 32'd0);
    nreq = 0;
    for (int i = 0; i < 50; i++) begin
      if (wr_req) nreq++;
      tick();
    end
    check("midrst_no_resume", 32'(nreq), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
